mac_input_skew: RTL and testbench

MAC_INPUT_SKEW -- requirements
Module: mac_input_skew

---
 rtl/mac_input_skew_if.sv | 14 +
 rtl/mac_input_skew.sv | 134 +++++++++++++
 tb/tb_mac_input_skew.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/mac_input_skew_if.sv
// Row-vector input handshake for the MAC input skew buffer.
// The producer drives valid/data/last; the skew block answers with ready.
interface mac_input_skew_if #(
  parameter int DATA_SIZE = 8,
  parameter int MAC_WIDTH = 8
);
  logic                           in_valid;
  logic                           in_ready;
  logic [MAC_WIDTH*DATA_SIZE-1:0] in_data;
  logic                           in_last;

  modport master (output in_valid, output in_data, output in_last, input  in_ready);
  modport slave  (input  in_valid, input  in_data, input  in_last, output in_ready);
endinterface

// File: rtl/mac_input_skew.sv
// Skews row vectors across MAC lanes: lane i is delayed by i cycles so the
// systolic array sees a diagonal wavefront. Also counts rows per tile.
module mac_input_skew #(
  parameter int DATA_SIZE = 8,
  parameter int MAC_WIDTH = 8
) (
  input  logic                           clock,
  input  logic                           reset,
  mac_input_skew_if.slave                in_if,
  output logic [MAC_WIDTH*DATA_SIZE-1:0] values_out,
  output logic [MAC_WIDTH-1:0]           lane_valid,
  output logic                           tile_done,
  output logic [15:0]                    tile_rows
);

  localparam int CNT_W = (MAC_WIDTH > 1) ? $clog2(MAC_WIDTH) : 1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_DRAIN  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             done_q, done_d;
  logic [15:0]      row_cnt_q, row_cnt_d;
  logic [15:0]      tile_rows_q, tile_rows_d;
  logic             accept_s;

  assign in_if.in_ready = (state_q != ST_DRAIN);
  assign accept_s       = in_if.in_valid & (state_q != ST_DRAIN);

  // Per-lane shift chains; lane i holds i+1 stages so its tail lags by i edges.
  for (genvar i = 0; i < MAC_WIDTH; i++) begin : g_lane
    logic [DATA_SIZE-1:0] dat_q [0:i];
    logic [i:0]           vld_q;

    // Shift every edge; a non-accept cycle injects a zero bubble.
    always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
        for (int j = 0; j <= i; j++) begin
          dat_q[j] <= '0;
        end
        vld_q <= '0;
      end else begin
        dat_q[0] <= accept_s ? in_if.in_data[i*DATA_SIZE +: DATA_SIZE] : '0;
        vld_q[0] <= accept_s;
        for (int j = 1; j <= i; j++) begin
          dat_q[j] <= dat_q[j-1];
          vld_q[j] <= vld_q[j-1];
        end
      end
    end

    assign values_out[i*DATA_SIZE +: DATA_SIZE] = dat_q[i];
    assign lane_valid[i]                        = vld_q[i];
  end

  // Next-state, drain countdown, done pulse and per-tile row accounting.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    done_d      = 1'b0;
    row_cnt_d   = row_cnt_q;
    tile_rows_d = tile_rows_q;

    if (accept_s) begin
      if (in_if.in_last) begin
        tile_rows_d = row_cnt_q + 16'd1;
        row_cnt_d   = 16'd0;
      end else begin
        row_cnt_d   = row_cnt_q + 16'd1;
      end
    end else begin
      row_cnt_d = row_cnt_q;
    end

    case (state_q)
      ST_IDLE, ST_STREAM: begin
        if (accept_s) begin
          if (in_if.in_last) begin
            // A one-lane array has nothing left in flight after the accept edge.
            if (MAC_WIDTH == 1) begin
              state_d = ST_IDLE;
              done_d  = 1'b1;
            end else begin
              state_d = ST_DRAIN;
              cnt_d   = CNT_W'(MAC_WIDTH - 1);
            end
          end else begin
            state_d = ST_STREAM;
          end
        end else begin
          state_d = state_q;
        end
      end
      ST_DRAIN: begin
        if (cnt_q <= CNT_W'(1)) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          done_d  = 1'b1;
        end else begin
          cnt_d   = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Control state registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      done_q      <= 1'b0;
      row_cnt_q   <= 16'd0;
      tile_rows_q <= 16'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      done_q      <= done_d;
      row_cnt_q   <= row_cnt_d;
      tile_rows_q <= tile_rows_d;
    end
  end

  assign tile_done = done_q;
  assign tile_rows = tile_rows_q;

endmodule

// File: tb/tb_mac_input_skew.sv
// Directed bench for mac_input_skew (8 lanes x 8 bits) with hand-derived expectations.
module tb_mac_input_skew;

  logic        clock;
  logic        reset;
  logic [63:0] values_out;
  logic [7:0]  lane_valid;
  logic        tile_done;
  logic [15:0] tile_rows;

  int n_total = 0;
  int n_bad   = 0;

  mac_input_skew_if #(.DATA_SIZE(8), .MAC_WIDTH(8)) bus ();

  mac_input_skew #(.DATA_SIZE(8), .MAC_WIDTH(8)) dut (
    .clock      (clock),
    .reset      (reset),
    .in_if      (bus),
    .values_out (values_out),
    .lane_valid (lane_valid),
    .tile_done  (tile_done),
    .tile_rows  (tile_rows)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic v, input logic [63:0] d, input logic l);
    bus.in_valid = v;
    bus.in_data  = d;
    bus.in_last  = l;
  endtask

  initial begin
    reset = 1'b0;
    drive(1'b0, 64'd0, 1'b0);
    #12;
    chk("rst_values", values_out, 64'd0);
    chk("rst_lane_valid", {56'd0, lane_valid}, 64'd0);
    chk("rst_tile_done", {63'd0, tile_done}, 64'd0);
    chk("rst_tile_rows", {48'd0, tile_rows}, 64'd0);
    chk("rst_in_ready", {63'd0, bus.in_ready}, 64'd1);
    @(negedge clock);
    reset = 1'b1;

    // Single row, lanes 0x01..0x08, last
    drive(1'b1, 64'h0807060504030201, 1'b1);
    step();
    drive(1'b0, 64'd0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      if (i > 0) step();
      chk("single_values", values_out, 64'(i + 1) << (8 * i));
      chk("single_valid", {56'd0, lane_valid}, 64'd1 << i);
      chk("single_ready", {63'd0, bus.in_ready}, (i == 7) ? 64'd1 : 64'd0);
      chk("single_done", {63'd0, tile_done}, (i == 7) ? 64'd1 : 64'd0);
    end
    chk("single_rows", {48'd0, tile_rows}, 64'd1);
    step();
    chk("single_done_pulse", {63'd0, tile_done}, 64'd0);
    chk("single_flushed", {56'd0, lane_valid}, 64'd0);

    // Back-to-back four rows
    for (int e = 0; e <= 11; e++) begin
      if (e < 4) drive(1'b1, {8{8'(8'h10 * (e + 1))}}, e == 3);
      else       drive(1'b0, 64'd0, 1'b0);
      step();
      if (e >= 7 && e <= 10) begin
        chk("b2b_lane7", {56'd0, values_out[63:56]}, 64'(8'h10 * (e - 6)));
        chk("b2b_lane7_valid", {63'd0, lane_valid[7]}, 64'd1);
      end
      chk("b2b_ready", {63'd0, bus.in_ready}, (e >= 3 && e <= 9) ? 64'd0 : 64'd1);
      chk("b2b_done", {63'd0, tile_done}, (e == 10) ? 64'd1 : 64'd0);
      if (e == 10) chk("b2b_rows", {48'd0, tile_rows}, 64'd4);
    end

    // Bubble between two rows
    for (int e = 0; e <= 10; e++) begin
      if (e == 0)      drive(1'b1, {8{8'hA1}}, 1'b0);
      else if (e == 2) drive(1'b1, {8{8'hB2}}, 1'b1);
      else             drive(1'b0, 64'd0, 1'b0);
      step();
      if (e == 3) begin
        chk("bub_lane3_a", {56'd0, values_out[31:24]}, 64'hA1);
        chk("bub_lane3_a_v", {63'd0, lane_valid[3]}, 64'd1);
      end
      if (e == 4) begin
        chk("bub_lane3_gap", {56'd0, values_out[31:24]}, 64'h00);
        chk("bub_lane3_gap_v", {63'd0, lane_valid[3]}, 64'd0);
      end
      if (e == 5) begin
        chk("bub_lane3_b", {56'd0, values_out[31:24]}, 64'hB2);
        chk("bub_lane3_b_v", {63'd0, lane_valid[3]}, 64'd1);
      end
      chk("bub_done", {63'd0, tile_done}, (e == 9) ? 64'd1 : 64'd0);
      if (e == 9) chk("bub_rows", {48'd0, tile_rows}, 64'd2);
    end

    // Backpressure: valid held through drain
    drive(1'b1, {8{8'h55}}, 1'b1);
    step();
    drive(1'b1, {8{8'h66}}, 1'b0);
    for (int e = 1; e <= 7; e++) begin
      step();
      chk("bp_ready", {63'd0, bus.in_ready}, (e == 7) ? 64'd1 : 64'd0);
      chk("bp_valid", {56'd0, lane_valid}, 64'd1 << e);
      chk("bp_values", values_out, 64'h55 << (8 * e));
    end
    chk("bp_done", {63'd0, tile_done}, 64'd1);
    drive(1'b1, {8{8'h66}}, 1'b1);
    step();
    drive(1'b0, 64'd0, 1'b0);
    chk("bp_accept_valid", {56'd0, lane_valid}, 64'h01);
    chk("bp_accept_lane0", {56'd0, values_out[7:0]}, 64'h66);
    for (int e = 1; e <= 7; e++) step();
    chk("bp_done2", {63'd0, tile_done}, 64'd1);
    chk("bp_rows2", {48'd0, tile_rows}, 64'd1);

    // Reset mid-drain with counter at 3
    drive(1'b1, {8{8'h77}}, 1'b1);
    step();
    drive(1'b0, 64'd0, 1'b0);
    for (int e = 1; e <= 4; e++) step();
    chk("mid_ready_pre", {63'd0, bus.in_ready}, 64'd0);
    #1 reset = 1'b0;
    #1;
    chk("mid_values", values_out, 64'd0);
    chk("mid_valid", {56'd0, lane_valid}, 64'd0);
    chk("mid_done", {63'd0, tile_done}, 64'd0);
    chk("mid_rows", {48'd0, tile_rows}, 64'd0);
    chk("mid_ready", {63'd0, bus.in_ready}, 64'd1);
    step();
    step();
    @(negedge clock);
    reset = 1'b1;
    drive(1'b1, {8{8'h99}}, 1'b1);
    step();
    drive(1'b0, 64'd0, 1'b0);
    chk("post_rst_accept", {56'd0, lane_valid}, 64'h01);
    chk("post_rst_lane0", {56'd0, values_out[7:0]}, 64'h99);
    for (int e = 1; e <= 7; e++) begin
      step();
      chk("post_rst_done", {63'd0, tile_done}, (e == 7) ? 64'd1 : 64'd0);
    end

    // Row counter wrap: 65537 rows
    for (int n = 0; n <= 65536; n++) begin
      drive(1'b1, 64'd0, n == 65536);
      step();
    end
    drive(1'b0, 64'd0, 1'b0);
    for (int e = 1; e <= 7; e++) step();
    chk("wrap_done", {63'd0, tile_done}, 64'd1);
    chk("wrap_rows", {48'd0, tile_rows}, 64'd1);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
